// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    ACCESS = S_ACCESS,
    RESP   = S_RESP
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side fetch/data ports plus the unified memory bus seen by the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic [WORD_SIZE-1:0] InstrAddr;
  logic                 InstrReq;
  logic [WORD_SIZE-1:0] InstrIn;
  logic                 InstrWaitreq;

  logic [WORD_SIZE-1:0] DataAddr;
  logic [WORD_SIZE-1:0] DataOut;
  logic                 ReadData;
  logic                 WriteData;
  logic [WORD_SIZE-1:0] DataIn;
  logic                 DataWaitreq;

  logic [WORD_SIZE-1:0] MemAddr;
  logic [WORD_SIZE-1:0] MemWrData;
  logic                 MemRead;
  logic                 MemWrite;
  logic [WORD_SIZE-1:0] MemRdData;

  modport slave (
    input  InstrAddr, InstrReq, DataAddr, DataOut, ReadData, WriteData, MemRdData,
    output InstrIn, InstrWaitreq, DataIn, DataWaitreq, MemAddr, MemWrData, MemRead, MemWrite
  );

  modport master (
    output InstrAddr, InstrReq, DataAddr, DataOut, ReadData, WriteData, MemRdData,
    input  InstrIn, InstrWaitreq, DataIn, DataWaitreq, MemAddr, MemWrData, MemRead, MemWrite
  );

endinterface

// File: rtl/mem_arb_latency_counter.sv
// Access latency timer: loaded when an access starts, flags done on the last ACCESS cycle.
module mem_arb_latency_counter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(MEM_LATENCY);
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data; data wins unless fetch has starved.
// Define MEM_PORT_ARB_STATS_EN to build the grant/stall performance counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  mem_port_arbiter_if.slave   bus,
  output logic [15:0]         StatInstrGrants,
  output logic [15:0]         StatDataGrants,
  output logic [15:0]         StatStallCycles
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t           state_q, state_d;
  grant_t               gnt_q, gnt_d;
  logic                 wr_q, wr_d;
  logic                 first_q, first_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdat_q, wdat_d;
  logic [SW-1:0]        starve_q, starve_d;

  logic i_req, d_req, any_req, pick_i;
  logic cnt_load, cnt_done;
  logic in_access, in_resp;
  logic i_done, d_done;
  logic instr_wait, data_wait;

  assign i_req   = bus.InstrReq;
  assign d_req   = bus.ReadData | bus.WriteData;
  assign any_req = i_req | d_req;
  assign pick_i  = i_req && (!d_req || (starve_q == SW'(STARVE_LIMIT)));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    first_d  = first_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    starve_d = starve_q;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = ACCESS;
          first_d  = 1'b1;
          cnt_load = 1'b1;
          if (pick_i) begin
            gnt_d    = GNT_I;
            wr_d     = 1'b0;
            addr_d   = bus.InstrAddr;
            wdat_d   = '0;
            starve_d = '0;
          end else begin
            gnt_d  = GNT_D;
            wr_d   = bus.WriteData;
            addr_d = bus.DataAddr;
            wdat_d = bus.DataOut;
            // pick_i is forced at the limit, so this cannot overflow
            if (i_req) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end
      ACCESS: begin
        first_d = 1'b0;
        if (cnt_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_I;
      wr_q     <= 1'b0;
      first_q  <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      first_q  <= first_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      starve_q <= starve_d;
    end
  end

  mem_arb_latency_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_lat (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .load_i (cnt_load),
    .en_i   (state_q == ACCESS),
    .done_o (cnt_done)
  );

  // Every output is forced low while Reset is high, whatever the FSM holds.
  assign in_access = (state_q == ACCESS) && !Reset;
  assign in_resp   = (state_q == RESP) && !Reset;

  assign i_done = in_resp && (gnt_q == GNT_I) && i_req;
  assign d_done = in_resp && (gnt_q == GNT_D) && d_req;

  assign instr_wait = !Reset && i_req && !i_done;
  assign data_wait  = !Reset && d_req && !d_done;

  assign bus.MemRead      = in_access && first_q && !wr_q;
  assign bus.MemWrite     = in_access && first_q && wr_q;
  assign bus.MemAddr      = in_access ? addr_q : '0;
  assign bus.MemWrData    = (in_access && wr_q) ? wdat_q : '0;
  assign bus.InstrIn      = i_done ? bus.MemRdData : '0;
  assign bus.DataIn       = (d_done && !wr_q) ? bus.MemRdData : '0;
  assign bus.InstrWaitreq = instr_wait;
  assign bus.DataWaitreq  = data_wait;

`ifdef MEM_PORT_ARB_STATS_EN
  logic [15:0] stat_i_q, stat_d_q, stat_s_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_s_q <= '0;
    end else begin
      if (i_done) stat_i_q <= stat_i_q + 16'd1;
      if (d_done) stat_d_q <= stat_d_q + 16'd1;
      if (instr_wait || data_wait) stat_s_q <= stat_s_q + 16'd1;
    end
  end

  assign StatInstrGrants = stat_i_q;
  assign StatDataGrants  = stat_d_q;
  assign StatStallCycles = stat_s_q;
`else
  assign StatInstrGrants = '0;
  assign StatDataGrants  = '0;
  assign StatStallCycles = '0;
`endif

endmodule
